// File: rtl/femto_clkdiv.sv
// femto_clkdiv: multi-channel clock-enable generator with a settle/lock flag.
// Each channel emits registered one-cycle ce pulses at a configurable rate.
// Default build: integer divider per channel (period = cfg cycles, cfg=0 off).
// Optional build macro FEMTO_CLKDIV_FRAC_EN: every channel becomes a fractional
// NCO (phase accumulator, ce = carry-out, average rate cfg/2^WIDTH).
//
// Write interface: wr_en is a single-cycle strobe with no back-pressure; every
// cycle in which wr_en=1 and wr_chan < CHANNELS is exactly one accepted write.
// Out-of-range channel numbers are silently dropped and do not touch lock state.
module femto_clkdiv #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16,
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] ce,
  output logic                locked
);

  localparam logic [WIDTH-1:0] DEF_CFG  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_CNT  = (DEFAULT_DIV == 0) ? '0 : WIDTH'(DEFAULT_DIV - 1);
  localparam logic [CW:0]      NCH      = CHANNELS[CW:0];
  localparam logic [15:0]      LOCK_MAX = 16'(LOCK_CYCLES);

  logic [WIDTH-1:0]    cfg_q [CHANNELS];
  logic [WIDTH-1:0]    cfg_d [CHANNELS];
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] ce_q;
  logic [CHANNELS-1:0] ce_d;
  logic [15:0]         lock_cnt_q;
  logic [15:0]         lock_cnt_d;
  logic                locked_q;
  logic                locked_d;
  logic                wr_valid;

`ifdef FEMTO_CLKDIV_FRAC_EN
  logic [WIDTH:0]      sum [CHANNELS];
`endif

  // A write only counts when it addresses an existing channel.
  assign wr_valid = wr_en && ({1'b0, wr_chan} < NCH);

  // Per-channel next state: free-running divide/accumulate, overridden by a write.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cfg_d[i] = cfg_q[i];
      cnt_d[i] = cnt_q[i];
      ce_d[i]  = 1'b0;
`ifdef FEMTO_CLKDIV_FRAC_EN
      sum[i]   = {1'b0, cnt_q[i]} + {1'b0, cfg_q[i]};
      cnt_d[i] = sum[i][WIDTH-1:0];
      ce_d[i]  = sum[i][WIDTH];
`else
      if (cfg_q[i] == '0) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == '0) begin
        ce_d[i]  = 1'b1;
        cnt_d[i] = cfg_q[i] - WIDTH'(1);
      end else begin
        cnt_d[i] = cnt_q[i] - WIDTH'(1);
      end
`endif
      // A write restarts the channel and swallows the pulse it would have made.
      if (wr_valid && (wr_chan == CW'(i))) begin
        cfg_d[i] = wr_data;
        ce_d[i]  = 1'b0;
`ifdef FEMTO_CLKDIV_FRAC_EN
        cnt_d[i] = '0;
`else
        cnt_d[i] = (wr_data == '0) ? '0 : (wr_data - WIDTH'(1));
`endif
      end
    end
  end

  // Lock counter: cleared by any accepted write, saturates at LOCK_CYCLES.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (wr_valid) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + 16'd1;
    end
    // A write in the would-be lock cycle leaves lock_cnt_d at 0, so locked stays low.
    locked_d = (lock_cnt_d == LOCK_MAX);
  end

  // Channel registers; reset reloads the default divisor and aborts any period.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cfg_q[i] <= DEF_CFG;
        cnt_q[i] <= DEF_CNT;
      end
      ce_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  // Lock registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign ce     = ce_q;
  assign locked = locked_q;

endmodule
